hazard_detector: RTL and testbench
==================================

HAZARD_DETECTOR -- requirements
Module: hazard_detector

Interface
REQ-001 Parameter CNT_W, default 32, width of each performance counter.
REQ-002 clk  input  1  pipeline clock; single clock domain.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 ID_rs1_i, ID_rs2_i  input  rv32i_reg  source registers of the instruction in decode.
REQ-005 ID_uses_rs1_i, ID_uses_rs2_i  input  1 each  decode instruction reads rs1/rs2.
REQ-006 EX_rd_i  input  rv32i_reg  destination of the instruction in execute.
REQ-007 EX_is_load_i  input  1  execute instruction is a load (LB/LH/LW/LBU/LHU).
REQ-008 EX_br_taken_i  input  1  execute resolved a redirect (taken branch, JAL, JALR).
REQ-009 imem_read_i, imem_resp_i  input  1 each  instruction-memory request / response.
REQ-010 dmem_read_i, dmem_write_i, dmem_resp_i  input  1 each  data-memory request / response.
REQ-011 PC_load_o, IF_ID_load_o, ID_EX_load_o, EX_MEM_load_o, MEM_WB_load_o  output  1 each  pipeline-register enables.
REQ-012 IF_ID_flush_o, ID_EX_bubble_o  output  1 each  load a NOP into IF/ID or ID/EX.
REQ-013 stall_o  output  1  pipeline is not fully advancing this cycle.
REQ-014 load_use_cnt_o, mem_stall_cyc_o, mem_stall_evt_o, flush_cnt_o  output  CNT_W each  performance counters.

Function
REQ-015 mem_busy SHALL be (imem_read_i & ~imem_resp_i) | ((dmem_read_i | dmem_write_i) & ~dmem_resp_i).
REQ-016 load_use SHALL be EX_is_load_i & (EX_rd_i != 0) & ((ID_uses_rs1_i & EX_rd_i == ID_rs1_i) | (ID_uses_rs2_i & EX_rd_i == ID_rs2_i)).
REQ-017 Priority (highest first): rst, mem_busy, EX_br_taken_i, load_use, normal.
REQ-018 mem_busy: all five *_load_o = 0, IF_ID_flush_o = 0, ID_EX_bubble_o = 0, stall_o = 1.
REQ-019 EX_br_taken_i (not mem_busy): all loads = 1, IF_ID_flush_o = 1, ID_EX_bubble_o = 1, stall_o = 0.
REQ-020 load_use (neither above): PC_load_o = IF_ID_load_o = 0, ID_EX/EX_MEM/MEM_WB loads = 1, ID_EX_bubble_o = 1, stall_o = 1; exactly one bubble per load-use pair.
REQ-021 Normal: all loads = 1, flush/bubble = 0, stall_o = 0.
REQ-022 All outputs except counters SHALL be combinational in the current inputs; the controller adds zero cycles of latency.
REQ-023 A hazard coinciding with mem_busy SHALL NOT be acted on until the cycle mem_busy deasserts; inputs are held by the frozen pipeline and re-evaluated then.
REQ-024 FSM states RUN, MEM_STALL, LOAD_BUBBLE; reset state RUN.
REQ-025 Next state: mem_busy -> MEM_STALL; else load_use -> LOAD_BUBBLE; else RUN; evaluated from any state.
REQ-026 mem_stall_evt_o SHALL increment on each transition from another state into MEM_STALL; mem_stall_cyc_o SHALL increment every cycle mem_busy = 1.
REQ-027 load_use_cnt_o SHALL increment every cycle REQ-020 applies; flush_cnt_o SHALL increment every cycle REQ-019 applies.
REQ-028 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-029 Register x0 SHALL never cause a load-use stall.

Reset
REQ-030 While rst = 1: all *_load_o = 0, IF_ID_flush_o = ID_EX_bubble_o = 0, stall_o = 1, next state RUN, all counters cleared to 0 at the clock edge.
REQ-031 Reset asserted mid-stall SHALL abandon the stall; the first cycle after rst deasserts is evaluated from RUN.

Structure
REQ-032 hazard_state_t (RUN, MEM_STALL, LOAD_BUBBLE) SHALL live in a shared package namespace hazard alongside forwardingmux; rv32i_reg comes from rv32i_types.
REQ-033 One sub-module sat_counter (parameter W; inputs clk, rst, inc_i; output count_o) SHALL be instantiated four times.

Verification
REQ-034 EX: LW x5, EX_is_load=1; ID rs1=5, uses_rs1=1; no mem_busy -> PC_load=0, IF_ID_load=0, ID_EX_bubble=1, stall_o=1, load_use_cnt 0->1; next cycle with EX bubble -> all loads 1.
REQ-035 Same as REQ-034 with EX_rd=0, rs1=0 -> normal, no stall, counter unchanged.
REQ-036 dmem_read=1, dmem_resp=0 for 4 cycles, then resp=1 -> loads 0 for 4 cycles, mem_stall_cyc=4, mem_stall_evt=1, all loads 1 on the resp cycle.
REQ-037 EX_br_taken=1 with imem_read=1, imem_resp=0 for 2 cycles then resp -> frozen 2 cycles, then IF_ID_flush=1, ID_EX_bubble=1, flush_cnt=1.
REQ-038 Load-use held for 3 cycles of mem_busy -> no bubble during the stall, exactly one bubble after release, load_use_cnt=1.
REQ-039 CNT_W=4, 20 consecutive mem_busy cycles -> mem_stall_cyc=15; rst pulse mid-stall -> all counters 0, state RUN.

Source files
------------

// File: rtl/hazard.sv
// Hazard-unit namespace: controller state encoding and forwarding-mux selects.
package hazard;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    MEM_STALL   = 2'd1,
    LOAD_BUBBLE = 2'd2
  } hazard_state_t;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'd0,
    FWD_EX_MEM  = 2'd1,
    FWD_MEM_WB  = 2'd2
  } forwardingmux;

endpackage : hazard

// File: rtl/rv32i_types.sv
// Shared RV32I register-file types used across the pipeline.
package rv32i_types;

  typedef logic [4:0] rv32i_reg;

endpackage : rv32i_types

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : sat_counter

// File: rtl/hazard_detector.sv
// Pipeline hazard controller: combinational stall/flush/bubble enables plus
// registered performance counters tracking memory stalls, load-use and flushes.
module hazard_detector
  import rv32i_types::*;
  import hazard::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  rv32i_reg         ID_rs1_i,
  input  rv32i_reg         ID_rs2_i,
  input  logic             ID_uses_rs1_i,
  input  logic             ID_uses_rs2_i,
  input  rv32i_reg         EX_rd_i,
  input  logic             EX_is_load_i,
  input  logic             EX_br_taken_i,
  input  logic             imem_read_i,
  input  logic             imem_resp_i,
  input  logic             dmem_read_i,
  input  logic             dmem_write_i,
  input  logic             dmem_resp_i,
  output logic             PC_load_o,
  output logic             IF_ID_load_o,
  output logic             ID_EX_load_o,
  output logic             EX_MEM_load_o,
  output logic             MEM_WB_load_o,
  output logic             IF_ID_flush_o,
  output logic             ID_EX_bubble_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] load_use_cnt_o,
  output logic [CNT_W-1:0] mem_stall_cyc_o,
  output logic [CNT_W-1:0] mem_stall_evt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  hazard_state_t state_q;
  hazard_state_t state_d;

  logic mem_busy_s;
  logic load_use_s;
  logic rs1_hit_s;
  logic rs2_hit_s;

  logic inc_load_use_s;
  logic inc_stall_cyc_s;
  logic inc_stall_evt_s;
  logic inc_flush_s;

  assign mem_busy_s = (imem_read_i & ~imem_resp_i)
                    | ((dmem_read_i | dmem_write_i) & ~dmem_resp_i);

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign rs1_hit_s  = ID_uses_rs1_i & (EX_rd_i == ID_rs1_i);
  assign rs2_hit_s  = ID_uses_rs2_i & (EX_rd_i == ID_rs2_i);
  assign load_use_s = EX_is_load_i & (EX_rd_i != 5'd0) & (rs1_hit_s | rs2_hit_s);

  always_comb begin
    PC_load_o      = 1'b1;
    IF_ID_load_o   = 1'b1;
    ID_EX_load_o   = 1'b1;
    EX_MEM_load_o  = 1'b1;
    MEM_WB_load_o  = 1'b1;
    IF_ID_flush_o  = 1'b0;
    ID_EX_bubble_o = 1'b0;
    stall_o        = 1'b0;
    if (rst || mem_busy_s) begin
      // Freeze everything; held hazards are re-evaluated once memory answers.
      PC_load_o      = 1'b0;
      IF_ID_load_o   = 1'b0;
      ID_EX_load_o   = 1'b0;
      EX_MEM_load_o  = 1'b0;
      MEM_WB_load_o  = 1'b0;
      stall_o        = 1'b1;
    end else if (EX_br_taken_i) begin
      IF_ID_flush_o  = 1'b1;
      ID_EX_bubble_o = 1'b1;
    end else if (load_use_s) begin
      PC_load_o      = 1'b0;
      IF_ID_load_o   = 1'b0;
      ID_EX_bubble_o = 1'b1;
      stall_o        = 1'b1;
    end else begin
      stall_o        = 1'b0;
    end
  end

  always_comb begin
    state_d = RUN;
    if (mem_busy_s) begin
      state_d = MEM_STALL;
    end else if (load_use_s) begin
      state_d = LOAD_BUBBLE;
    end else begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign inc_stall_cyc_s = mem_busy_s;
  assign inc_stall_evt_s = mem_busy_s & (state_q != MEM_STALL);
  assign inc_flush_s     = ~mem_busy_s & EX_br_taken_i;
  assign inc_load_use_s  = ~mem_busy_s & ~EX_br_taken_i & load_use_s;

  sat_counter #(.W(CNT_W)) u_load_use_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (inc_load_use_s),
    .count_o (load_use_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_mem_stall_cyc (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (inc_stall_cyc_s),
    .count_o (mem_stall_cyc_o)
  );

  sat_counter #(.W(CNT_W)) u_mem_stall_evt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (inc_stall_evt_s),
    .count_o (mem_stall_evt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (inc_flush_s),
    .count_o (flush_cnt_o)
  );

endmodule : hazard_detector

// File: tb/tb_hazard_detector.sv
// Directed-vector bench for hazard_detector with 4-bit counters so that
// saturation is reachable in a short run.
module tb_hazard_detector;
  import rv32i_types::*;

  localparam int unsigned CNT_W = 4;

  // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB, flush, bubble, stall}
  localparam logic [7:0] V_NORMAL = 8'b11111_000;
  localparam logic [7:0] V_BRANCH = 8'b11111_110;
  localparam logic [7:0] V_LDUSE  = 8'b00111_011;
  localparam logic [7:0] V_FREEZE = 8'b00000_001;

  logic clk = 1'b0;
  logic rst;
  rv32i_reg id_rs1, id_rs2, ex_rd;
  logic uses_rs1, uses_rs2, ex_is_load, ex_br;
  logic imem_read, imem_resp, dmem_read, dmem_write, dmem_resp;
  logic pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld, ifid_flush, idex_bubble, stall;
  logic [CNT_W-1:0] lu_cnt, stall_cyc, stall_evt, flush_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hazard_detector #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .ID_rs1_i        (id_rs1),
    .ID_rs2_i        (id_rs2),
    .ID_uses_rs1_i   (uses_rs1),
    .ID_uses_rs2_i   (uses_rs2),
    .EX_rd_i         (ex_rd),
    .EX_is_load_i    (ex_is_load),
    .EX_br_taken_i   (ex_br),
    .imem_read_i     (imem_read),
    .imem_resp_i     (imem_resp),
    .dmem_read_i     (dmem_read),
    .dmem_write_i    (dmem_write),
    .dmem_resp_i     (dmem_resp),
    .PC_load_o       (pc_ld),
    .IF_ID_load_o    (ifid_ld),
    .ID_EX_load_o    (idex_ld),
    .EX_MEM_load_o   (exmem_ld),
    .MEM_WB_load_o   (memwb_ld),
    .IF_ID_flush_o   (ifid_flush),
    .ID_EX_bubble_o  (idex_bubble),
    .stall_o         (stall),
    .load_use_cnt_o  (lu_cnt),
    .mem_stall_cyc_o (stall_cyc),
    .mem_stall_evt_o (stall_evt),
    .flush_cnt_o     (flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sampled 1 time unit after inputs change, well away from the rising edge.
  task automatic check_ctrl(input string tag, input logic [7:0] exp);
    #1;
    check(tag, {24'd0, pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld,
                ifid_flush, idex_bubble, stall}, {24'd0, exp});
  endtask

  // Counters packed as {load_use, stall_cyc, stall_evt, flush}, one nibble each.
  task automatic check_cnt(input string tag, input logic [15:0] exp);
    check(tag, {16'd0, lu_cnt, stall_cyc, stall_evt, flush_cnt}, {16'd0, exp});
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    uses_rs1 = 1'b0; uses_rs2 = 1'b0; ex_is_load = 1'b0; ex_br = 1'b0;
    imem_read = 1'b0; imem_resp = 1'b0;
    dmem_read = 1'b0; dmem_write = 1'b0; dmem_resp = 1'b0;
  endtask

  task automatic load_x5_use_x5();
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; uses_rs1 = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    check_ctrl("reset_ctrl", V_FREEZE);
    @(negedge clk);
    check_cnt("reset_cnt", 16'h0000);

    rst = 1'b0;
    check_ctrl("normal", V_NORMAL);
    @(negedge clk);

    // LW x5 in EX, consumer of x5 in ID
    load_x5_use_x5();
    check_ctrl("lduse_rs1", V_LDUSE);
    check_cnt("lduse_cnt_before", 16'h0000);
    @(negedge clk);
    check_cnt("lduse_cnt_after", 16'h1000);
    ex_is_load = 1'b0;
    check_ctrl("lduse_released", V_NORMAL);
    @(negedge clk);
    check_cnt("one_bubble_only", 16'h1000);

    // rs2 match counts only when rs2 is actually read
    ex_is_load = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; uses_rs1 = 1'b0;
    id_rs2 = 5'd7; uses_rs2 = 1'b0;
    check_ctrl("match_not_used", V_NORMAL);
    uses_rs2 = 1'b1;
    check_ctrl("lduse_rs2", V_LDUSE);
    @(negedge clk);
    check_cnt("lduse_rs2_cnt", 16'h2000);

    // x0 never stalls
    ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
    check_ctrl("x0_no_stall", V_NORMAL);
    @(negedge clk);
    check_cnt("x0_cnt", 16'h2000);

    // data-memory miss for 4 cycles
    idle();
    dmem_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_ctrl("dmem_freeze", V_FREEZE);
      @(negedge clk);
    end
    dmem_resp = 1'b1;
    check_ctrl("dmem_resp", V_NORMAL);
    check_cnt("dmem_cnt", 16'h2410);
    @(negedge clk);
    check_cnt("dmem_cnt_hold", 16'h2410);

    // taken branch waiting on instruction fetch
    idle();
    ex_br = 1'b1; imem_read = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check_ctrl("br_frozen", V_FREEZE);
      @(negedge clk);
    end
    imem_resp = 1'b1;
    check_ctrl("br_flush", V_BRANCH);
    @(negedge clk);
    check_cnt("br_cnt", 16'h2621);

    // load-use held under a 3-cycle data-memory stall
    idle();
    load_x5_use_x5();
    dmem_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_ctrl("lduse_frozen", V_FREEZE);
      @(negedge clk);
    end
    dmem_resp = 1'b1;
    check_ctrl("lduse_after_mem", V_LDUSE);
    @(negedge clk);
    check_cnt("lduse_mem_cnt", 16'h3931);
    ex_is_load = 1'b0;
    check_ctrl("lduse_mem_release", V_NORMAL);
    @(negedge clk);

    // redirect outranks load-use
    idle();
    load_x5_use_x5();
    ex_br = 1'b1;
    check_ctrl("br_over_lduse", V_BRANCH);
    @(negedge clk);
    check_cnt("br_over_lduse_cnt", 16'h3932);

    // 20 consecutive busy cycles saturate the 4-bit cycle counter
    idle();
    imem_read = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check_ctrl("long_stall", V_FREEZE);
      @(negedge clk);
    end
    check_cnt("saturate", 16'h3F42);

    // reset mid-stall clears everything and restarts from RUN
    rst = 1'b1;
    check_ctrl("rst_mid_stall", V_FREEZE);
    @(negedge clk);
    check_cnt("rst_clears", 16'h0000);
    rst = 1'b0;
    check_ctrl("post_rst_busy", V_FREEZE);
    @(negedge clk);
    check_cnt("post_rst_evt", 16'h0110);
    idle();
    check_ctrl("final_normal", V_NORMAL);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_hazard_detector
